// File: rtl/fpu_inq_ctl.sv
// fpu_inq_ctl: FPU input queue control; occupancy, pointers, source select, in-order issue and PCX credits.
module fpu_inq_ctl #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             fp_req_vld,
    input  logic [1:0]       fp_req_pipe,
    input  logic             add_rdy,
    input  logic             mul_rdy,
    input  logic             div_rdy,
    output logic             inq_we,
    output logic [PTR_W-1:0] inq_waddr,
    output logic [PTR_W-1:0] inq_raddr,
    output logic             inq_fwrd,
    output logic             inq_fwrd_inv,
    output logic             inq_bp,
    output logic             inq_bp_inv,
    output logic             inq_add_vld,
    output logic             inq_mul_vld,
    output logic             inq_div_vld,
    output logic [PTR_W:0]   inq_cnt,
    output logic             fpu_pcx_credit,
    output logic             inq_ovfl
);
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, waddr_d1_q;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [1:0]       tag_q [DEPTH];
    logic [DEPTH-1:0] tvld_q;
    logic             we_d1_q, ovfl_q, credit_q;
    logic             nonempty, full, head_rdy, req_rdy, deq, fwd, issue;
    logic [1:0]       head, sel;

    always_comb begin
        head     = tag_q[rptr_q];
        nonempty = cnt_q != '0;
        full     = cnt_q == (PTR_W+1)'(DEPTH);
        head_rdy = head[1] ? (head[0] ? div_rdy : mul_rdy) : add_rdy;
        req_rdy  = fp_req_pipe[1] ? (fp_req_pipe[0] ? div_rdy : mul_rdy) : add_rdy;
        deq      = ~reset & nonempty & tvld_q[rptr_q] & head_rdy;
        fwd      = ~reset & ~nonempty & fp_req_vld & req_rdy;
        issue    = deq | fwd;
        sel      = nonempty ? head : fp_req_pipe;
        inq_we   = ~reset & fp_req_vld & ~fwd & ~full;
        rptr_d   = rptr_q + PTR_W'(deq);
        wptr_d   = wptr_q + PTR_W'(inq_we);
        cnt_d    = cnt_q + (PTR_W+1)'(inq_we) - (PTR_W+1)'(deq);
    end

    assign inq_waddr      = wptr_q;
    assign inq_raddr      = rptr_d;
    assign inq_fwrd       = fwd;
    assign inq_fwrd_inv   = ~fwd;
    // Head written on the last edge: the SRAM read at that edge saw stale data.
    assign inq_bp         = we_d1_q & (rptr_q == waddr_d1_q) & nonempty;
    assign inq_bp_inv     = ~inq_bp;
    assign inq_add_vld    = issue & ~sel[1];
    assign inq_mul_vld    = issue & sel[1] & ~sel[0];
    assign inq_div_vld    = issue & sel[1] & sel[0];
    assign inq_cnt        = cnt_q;
    assign fpu_pcx_credit = credit_q;
    assign inq_ovfl       = ovfl_q;

    always_ff @(posedge rclk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            tvld_q     <= '0;
            we_d1_q    <= 1'b0;
            waddr_d1_q <= '0;
            credit_q   <= 1'b0;
            ovfl_q     <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            we_d1_q    <= inq_we;
            waddr_d1_q <= wptr_q;
            credit_q   <= issue;
            // A same-cycle dequeue does not rescue a request arriving at a full queue.
            ovfl_q     <= ovfl_q | (fp_req_vld & full);
            if (deq) tvld_q[rptr_q] <= 1'b0;
            if (inq_we) tvld_q[wptr_q] <= 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (inq_we) tag_q[wptr_q] <= fp_req_pipe;
    end
endmodule

// File: doc/fpu_inq_ctl.md
Name: fpu_inq_ctl

Overview:
- Control for the FPU input queue; sits beside the FPU input datapath stage, which captures PCX request packets and holds the queue data.
- Tracks queue occupancy and write/read pointers for the DEPTH-entry input queue SRAM.
- Each cycle it picks the data source for the op pipes: direct forward, last-write bypass, or SRAM read.
- Issues requests in order to the add/mul/div pipes and returns one PCX credit per request consumed.

Parameters:
DEPTH, 16, queue entries; power of two, at least 2
PTR_W, 4, pointer width; equals log2(DEPTH)

Ports:
rclk  in  1  clock
reset  in  1  synchronous active-high reset
fp_req_vld  in  1  complete request packet captured by the input datapath this cycle
fp_req_pipe  in  2  request target: 00/01 add, 10 mul, 11 div
add_rdy  in  1  add pipe accepts an issue this cycle
mul_rdy  in  1  mul pipe accepts an issue this cycle
div_rdy  in  1  div pipe accepts an issue this cycle
inq_we  out  1  SRAM write enable
inq_waddr  out  PTR_W  SRAM write address
inq_raddr  out  PTR_W  SRAM read address; registered in SRAM, dout valid next cycle
inq_fwrd, inq_fwrd_inv  out  1 each  select the incoming packet; _inv is the exact complement
inq_bp, inq_bp_inv  out  1 each  select the delayed write data over SRAM dout; _inv is the exact complement
inq_add_vld, inq_mul_vld, inq_div_vld  out  1 each  issue strobes, at most one high per cycle
inq_cnt  out  PTR_W+1  occupancy, 0..DEPTH
fpu_pcx_credit  out  1  one-cycle pulse per request consumed
inq_ovfl  out  1  sticky overflow error

Behaviour:
- Clocking and reset: one clock, rclk. reset is synchronous and active-high. While reset is high and in the cycle after it, all of the following are 0: wptr, rptr, inq_cnt, we_d1, inq_ovfl, credit, and the target-tag array valids. All issue strobes and inq_we are forced 0 while reset is high.
- Reset mid-operation: queued entries are discarded and no credit is returned for them.
- State: wptr, rptr, cnt, DEPTH x 2-bit target tag array, we_d1 (registered inq_we), waddr_d1 (registered inq_waddr).
- Head target: tag[rptr] when cnt>0.
- Issue decision, combinational, one issue per cycle, strictly in order:
  - cnt>0: if the head target's rdy is high, strobe that pipe, set deq=1, inq_fwrd=0. There is no head-of-line bypass, even if a later entry's pipe is ready.
  - cnt==0, fp_req_vld=1, and the target's rdy is high: strobe that pipe, set inq_fwrd=1, no write (zero-latency forward).
  - Otherwise: no strobe, inq_fwrd=0.
- inq_bp = we_d1 & (rptr==waddr_d1) & (cnt>0). The head was written on the last edge, so the SRAM read at that edge returned stale data; the delayed write copy is used instead.
- inq_bp and inq_fwrd are never both 1.
- Enqueue: inq_we = fp_req_vld & ~inq_fwrd & (cnt<DEPTH). It writes slot wptr, sets tag[wptr]=fp_req_pipe, and wptr increments mod DEPTH.
- Overflow: fp_req_vld with cnt==DEPTH means the packet is dropped and inq_ovfl sets, sticky until reset. This holds even if a dequeue happens in the same cycle, because the credit returned that cycle cannot yet have been used.
- Dequeue: rptr increments mod DEPTH.
- inq_raddr = rptr_next (rptr+deq), so SRAM dout in the next cycle reflects the new head.
- cnt_next = cnt + enq - deq. A simultaneous enqueue and dequeue leaves cnt unchanged.
- fpu_pcx_credit is registered: it pulses 1 in the cycle after any dequeue or forward. Latency from consume to credit is 1.
- Pointer wrap: DEPTH-1 -> 0 with no bubble.
- Full versus empty is distinguished by cnt only.

Test Plan:
- Empty queue, add_rdy=1, fp_req_vld with pipe=01 -> same cycle inq_fwrd=1, inq_add_vld=1, inq_we=0; next cycle fpu_pcx_credit=1, inq_cnt=0.
- mul_rdy=0, three mul requests in cycles 0-2 -> inq_we at waddr 0,1,2 and inq_cnt=3. Raise mul_rdy in cycle 3 -> inq_mul_vld in cycles 3,4,5 with inq_bp=0; credits in cycles 4,5,6; cnt reaches 0.
- div_rdy=0, one div request in cycle 0, div_rdy=1 in cycle 1 -> cycle 1 inq_bp=1, inq_div_vld=1; next cycle inq_bp=0.
- Head targets div (div_rdy=0), second entry targets add (add_rdy=1) -> no issue of any strobe. Raise div_rdy -> div issues, then add issues next cycle.
- All rdy=0, 17 requests -> inq_cnt=16 and 16 writes; the 17th is dropped and inq_ovfl=1. The flag stays set after draining and clears only on reset.
- 20 requests with a stall then drain -> wptr and rptr wrap 15->0, issue order matches enqueue order. Asserting reset with cnt=5 -> next cycle cnt=0, no strobes, no credits.
